// File: rtl/ncl_phase_driver.sv
// Clocked wavefront sequencer for a dual-rail NCL block: drives HNULL/LNULL/DATA
// phases, watches synchronized return rails for completion, and hands back the decoded result.
module ncl_phase_driver #(
   parameter int WIDTH          = 24,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic [2*WIDTH-1:0] ncl_out,
   input  logic [2*WIDTH-1:0] ncl_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               error
);

   localparam int RAILS = 2 * WIDTH;
   localparam int DW    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [DW-1:0] ARM_AT  = DW'(3);
   localparam logic [DW-1:0] TMO_M1  = DW'(TIMEOUT_CYCLES - 1);
   localparam logic [DW-1:0] DW_MAX  = DW'(TIMEOUT_CYCLES);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] HNULL = 3'd1;
   localparam logic [2:0] LNULL = 3'd2;
   localparam logic [2:0] DATA  = 3'd3;
   localparam logic [2:0] OUT   = 3'd4;
   localparam logic [2:0] ERR   = 3'd5;

   logic [2:0]       state, state_nxt;
   logic [DW-1:0]    dwell;
   logic [WIDTH-1:0] operand;
   logic [RAILS-1:0] s1, s2, s2_prev;
   logic [RAILS-1:0] enc_op, ncl_nxt;
   logic [WIDTH-1:0] pair_ok, dec;
   logic             det_h, det_l, det_d, stable, armed, tmo, capture;

   for (genvar g = 0; g < WIDTH; g++) begin : g_pair
      assign enc_op[2*g+1] = operand[g];
      assign enc_op[2*g]   = ~operand[g];
      assign pair_ok[g]    = s2[2*g+1] ^ s2[2*g];
      assign dec[g]        = s2[2*g+1];
   end

   assign det_h  = &s2;
   assign det_l  = ~|s2;
   assign det_d  = &pair_ok;
   assign stable = (s2 == s2_prev);
   // The first three cycles of a phase still see rails from before the entry edge.
   assign armed  = (dwell >= ARM_AT);
   assign tmo    = (dwell == TMO_M1);

   assign in_ready = (state == IDLE);
   assign capture  = (state == DATA) && armed && det_d && stable;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (in_valid) state_nxt = HNULL;
         HNULL: if (armed && det_h && stable) state_nxt = LNULL;
                else if (tmo)                 state_nxt = ERR;
         LNULL: if (armed && det_l && stable) state_nxt = DATA;
                else if (tmo)                 state_nxt = ERR;
         DATA:  if (capture)                  state_nxt = OUT;
                else if (tmo)                 state_nxt = ERR;
         OUT:   if (out_valid && out_ready)   state_nxt = IDLE;
         ERR:   state_nxt = ERR;
         default: state_nxt = ERR;
      endcase
   end

   always_comb begin
      ncl_nxt = '1;
      case (state_nxt)
         LNULL:   ncl_nxt = '0;
         DATA:    ncl_nxt = enc_op;
         default: ncl_nxt = '1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         dwell     <= '0;
         operand   <= '0;
         s1        <= '1;
         s2        <= '1;
         s2_prev   <= '1;
         ncl_out   <= '1;
         out_valid <= 1'b0;
         out_data  <= '0;
         error     <= 1'b0;
      end else begin
         s1      <= ncl_in;
         s2      <= s1;
         s2_prev <= s2;
         state   <= state_nxt;
         ncl_out <= ncl_nxt;
         if (state_nxt != state)  dwell <= '0;
         else if (dwell != DW_MAX) dwell <= dwell + DW'(1);
         if (state == IDLE && in_valid) operand <= in_data;
         if (capture) begin
            out_data  <= dec;
            out_valid <= 1'b1;
         end else if (state == OUT && out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (state_nxt == ERR) begin
            error     <= 1'b1;
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ncl_phase_driver.sv
// Randomized bench: a behavioural dual-rail incrementer with per-rail skew sits on the
// loopback; results, latencies, hold behaviour, timeout and async reset are checked.
module tb_ncl_phase_driver;

   localparam int W   = 24;
   localparam int R   = 2 * W;
   localparam int TMO = 16;
   localparam logic [W-1:0] MASK = '1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic [R-1:0] ncl_out;
   logic [R-1:0] ncl_in;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         error;

   int n_chk = 0;
   int n_err = 0;

   logic         stuck = 1'b0;
   logic [1:0]   skew [R];
   logic [R-1:0] hist [3];
   logic [R-1:0] rails, ncl_in_c;

   ncl_phase_driver #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .ncl_out(ncl_out), .ncl_in(ncl_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .error(error)
   );

   always #5 clk = ~clk;

   // Dual-rail incrementer seen as a function of clean wavefronts on its input.
   function automatic logic [R-1:0] inc_model(input logic [R-1:0] r);
      logic [W-1:0] v;
      logic [R-1:0] o;
      if (&r) return '1;
      if (r == '0) return '0;
      v = '0;
      for (int i = 0; i < W; i++) v[i] = r[2*i+1];
      v = v + 1'b1;
      o = '0;
      for (int i = 0; i < W; i++) begin
         o[2*i+1] = v[i];
         o[2*i]   = ~v[i];
      end
      return o;
   endfunction

   always_comb begin
      rails    = inc_model(ncl_out);
      ncl_in_c = rails;
      for (int i = 0; i < R; i++)
         if (skew[i] != 2'd0) ncl_in_c[i] = hist[skew[i] - 2'd1][i];
      if (stuck) ncl_in_c[5:4] = 2'b11;
   end
   assign ncl_in = ncl_in_c;

   always @(posedge clk) begin
      hist[0] <= rails;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_error", error, 0);
      chk("rst_ncl_out", ncl_out, {R{1'b1}});
   endtask

   // One operand through the block with out_ready held high.
   task automatic xfer(input logic [W-1:0] op, input bit exact);
      int w;
      int lat;
      w = 0;
      while (!in_ready && w < 100) begin tick(); w++; end
      chk("in_ready_wait", in_ready, 1);
      in_valid = 1'b1;
      in_data  = op;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin tick(); lat++; end
      chk("out_valid", out_valid, 1);
      if (exact) chk("latency", lat, 12);
      chk("out_data", out_data, (op + 1'b1) & MASK);
      chk("error_low", error, 0);
      tick();
      chk("out_valid_clr", out_valid, 0);
      chk("in_ready_ret", in_ready, 1);
   endtask

   initial begin
      for (int i = 0; i < R; i++) skew[i] = 2'd0;
      #1 rst = 1'b1;
      #2 chk_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      xfer(24'h000005, 1'b1);
      xfer(24'hFFFFFF, 1'b1);
      xfer(24'h7FFFFF, 1'b1);

      // Consumer stalls: result held, in_valid ignored.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 24'h123456;
      tick();
      in_valid  = 1'b0;
      begin
         int lat;
         lat = 0;
         while (!out_valid && lat < 100) begin tick(); lat++; end
         chk("hold_latency", lat, 12);
      end
      for (int k = 0; k < 20; k++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = W'($urandom);
         tick();
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, 24'h123457);
         chk("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("hold_release", out_valid, 0);
      chk("hold_in_ready_ret", in_ready, 1);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("no_phantom", out_valid, 0);
         chk("data_kept", out_data, 24'h123457);
      end

      // Stuck high-null pair: LNULL never completes.
      stuck    = 1'b1;
      in_valid = 1'b1;
      in_data  = 24'h0000AA;
      tick();
      in_valid = 1'b0;
      begin
         int lat;
         lat = 0;
         while (!error && lat < 200) begin tick(); lat++; end
         chk("tmo_edge", lat, 4 + TMO);
      end
      chk("tmo_ncl_out", ncl_out, {R{1'b1}});
      chk("tmo_in_ready", in_ready, 0);
      chk("tmo_out_valid", out_valid, 0);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         tick();
         chk("err_sticky", error, 1);
         chk("err_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      stuck    = 1'b0;
      #2 rst = 1'b1;
      #1 chk_reset();
      #2 rst = 1'b0;

      // Abort during DATA: immediate reset values, then normal operation.
      xfer(24'h00ABCD, 1'b1);
      in_valid = 1'b1;
      in_data  = 24'h000777;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      #2 rst = 1'b1;
      #1 chk_reset();
      #2 rst = 1'b0;
      xfer(24'h000010, 1'b1);

      // Skewed loopback.
      for (int n = 0; n < 200; n++) begin
         logic [W-1:0] op;
         for (int i = 0; i < R; i++) skew[i] = 2'($urandom_range(0, 3));
         op = (n % 17 == 0) ? MASK : W'($urandom);
         xfer(op, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
